// File: rtl/sram_cmd_ctrl.sv
// 23LC-style SPI SRAM command decoder and byte-wide memory array.
// Decodes command/address/data frames from the SPI shift stage and serves read data back to it.
module sram_cmd_ctrl #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       tx_req,
    output logic [7:0] tx_byte,
    output logic [2:0] spi_opcode,
    output logic       busy,
    output logic       illegal_cmd
);

    localparam int unsigned ADDR_BYTES = (ADDR_W + 7) / 8;
    localparam int unsigned DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [1:0]        ABYTE_LAST = 2'(ADDR_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_IGNORE
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        abyte_q;
    logic              is_read_q;
    logic              fetch_first_q;
    logic [7:0]        tx_byte_q;
    logic [2:0]        opcode_q;
    logic              illegal_q;
    logic [7:0]        mem_q [DEPTH];

    logic [ADDR_W+7:0] addr_cat_d;
    logic [ADDR_W-1:0] addr_shift_d;
    logic              wr_en_d;
    logic              fetch_d;

    // Big-endian shift; bits above ADDR_W fall off the top.
    assign addr_cat_d   = {addr_q, rx_byte};
    assign addr_shift_d = addr_cat_d[ADDR_W-1:0];
    assign wr_en_d      = rst_n && !cs_n && rx_valid && (state_q == S_WDATA);
    // Entry fetch and a coincident tx_req collapse into a single fetch.
    assign fetch_d      = !cs_n && (state_q == S_RDATA) && (fetch_first_q || tx_req);

    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            mem_q[addr_q] <= rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            abyte_q       <= '0;
            is_read_q     <= 1'b0;
            fetch_first_q <= 1'b0;
            tx_byte_q     <= '0;
            opcode_q      <= 3'b000;
            illegal_q     <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            if (cs_n) begin
                state_q       <= S_IDLE;
                opcode_q      <= 3'b000;
                fetch_first_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q  <= S_CMD;
                        opcode_q <= 3'b010;
                    end
                    S_CMD: begin
                        if (rx_valid) begin
                            if (rx_byte == 8'h02 || rx_byte == 8'h03) begin
                                state_q   <= S_ADDR;
                                is_read_q <= (rx_byte == 8'h03);
                                abyte_q   <= '0;
                            end else begin
                                state_q   <= S_IGNORE;
                                opcode_q  <= 3'b000;
                                illegal_q <= 1'b1;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (rx_valid) begin
                            addr_q <= addr_shift_d;
                            if (abyte_q == ABYTE_LAST) begin
                                if (is_read_q) begin
                                    state_q       <= S_RDATA;
                                    opcode_q      <= 3'b011;
                                    fetch_first_q <= 1'b1;
                                end else begin
                                    state_q <= S_WDATA;
                                end
                            end else begin
                                abyte_q <= abyte_q + 2'd1;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (rx_valid) begin
                            addr_q <= addr_q + ADDR_ONE;
                        end
                    end
                    S_RDATA: begin
                        if (fetch_d) begin
                            tx_byte_q     <= mem_q[addr_q];
                            addr_q        <= addr_q + ADDR_ONE;
                            fetch_first_q <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign tx_byte     = tx_byte_q;
    assign spi_opcode  = opcode_q;
    assign busy        = (state_q != S_IDLE);
    assign illegal_cmd = illegal_q;

endmodule

// File: tb/tb_sram_cmd_ctrl.sv
// Randomized and directed bench for sram_cmd_ctrl against a frame-level reference model.
module tb_sram_cmd_ctrl;

    localparam int unsigned AW = 8;
    localparam int          AB = (AW + 7) / 8;

    logic       clk;
    logic       rst_n;
    logic       cs_n;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       tx_req;
    logic [7:0] tx_byte;
    logic [2:0] spi_opcode;
    logic       busy;
    logic       illegal_cmd;

    sram_cmd_ctrl #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs_n       (cs_n),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .tx_req     (tx_req),
        .tx_byte    (tx_byte),
        .spi_opcode (spi_opcode),
        .busy       (busy),
        .illegal_cmd(illegal_cmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Frame-level model: open flag, count of accepted bytes, command byte, address, memory image.
    bit          m_open = 1'b0;
    int          m_nb = 0;
    logic [7:0]  m_cmd = 8'h00;
    logic [AW-1:0] m_addr = '0;
    bit          m_pend = 1'b0;
    logic [7:0]  m_tx = 8'h00;
    bit          m_ill = 1'b0;
    logic [7:0]  m_mem [256];
    logic [2:0]  m_op;

    function automatic bit legal(input logic [7:0] c);
        return (c == 8'h02) || (c == 8'h03);
    endfunction

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_open = 1'b0; m_nb = 0; m_addr = '0; m_pend = 1'b0; m_tx = 8'h00; m_ill = 1'b0;
        end else if (cs_n) begin
            m_open = 1'b0; m_ill = 1'b0; m_pend = 1'b0;
        end else if (!m_open) begin
            m_open = 1'b1; m_nb = 0; m_ill = 1'b0;
        end else begin
            m_ill = 1'b0;
            if (m_cmd == 8'h03 && m_nb > AB) begin
                if (m_pend || tx_req) begin
                    m_tx = m_mem[m_addr];
                    m_addr = m_addr + 1'b1;
                    m_pend = 1'b0;
                end
            end else if (rx_valid) begin
                if (m_nb == 0) begin
                    m_cmd = rx_byte;
                    m_ill = !legal(rx_byte);
                    m_nb = 1;
                end else if (legal(m_cmd)) begin
                    if (m_nb <= AB) begin
                        m_addr = AW'({m_addr, rx_byte});
                        m_nb++;
                        if (m_nb > AB && m_cmd == 8'h03) m_pend = 1'b1;
                    end else begin
                        m_mem[m_addr] = rx_byte;
                        m_addr = m_addr + 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (!m_open || (m_nb > 0 && !legal(m_cmd))) m_op = 3'b000;
            else if (m_cmd == 8'h03 && m_nb > AB)       m_op = 3'b011;
            else                                        m_op = 3'b010;
            cmp("tx_byte", tx_byte, m_tx);
            cmp("spi_opcode", {5'b0, spi_opcode}, {5'b0, m_op});
            cmp("busy", {7'b0, busy}, {7'b0, m_open});
            cmp("illegal_cmd", {7'b0, illegal_cmd}, {7'b0, m_ill});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1; rx_byte = b; tick();
        rx_valid = 1'b0; tick();
    endtask

    task automatic cs_low();
        cs_n = 1'b0; tick();
    endtask

    task automatic cs_high();
        cs_n = 1'b1; tick(); tick();
    endtask

    task automatic pulse_tx();
        tx_req = 1'b1; tick();
        tx_req = 1'b0; tick();
    endtask

    logic [7:0] rb;
    int idx;
    int len;

    initial begin
        rst_n = 1'b0; cs_n = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; tx_req = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        cmp("rst_tx", tx_byte, 8'h00);
        cmp("rst_op", {5'b0, spi_opcode}, 8'h00);
        cmp("rst_busy", {7'b0, busy}, 8'h00);
        cmp("rst_ill", {7'b0, illegal_cmd}, 8'h00);
        rst_n = 1'b1; tick();

        // Fill the whole array with a known pattern so every read is defined.
        cs_low(); send_byte(8'h02); send_byte(8'h00);
        for (int i = 0; i < 256; i++) send_byte(8'(i) ^ 8'h5A);
        cs_high();

        // Write burst
        cs_low();
        cmp("wr_op_cmd", {5'b0, spi_opcode}, 8'h02);
        send_byte(8'h02); send_byte(8'h10);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        cmp("wr_op_data", {5'b0, spi_opcode}, 8'h02);
        cs_high();
        cmp("wr_op_end", {5'b0, spi_opcode}, 8'h00);

        // Read burst
        cs_low(); send_byte(8'h03); send_byte(8'h10);
        cmp("rd_first", tx_byte, 8'hAA);
        cmp("rd_op", {5'b0, spi_opcode}, 8'h03);
        pulse_tx(); cmp("rd_second", tx_byte, 8'hBB);
        pulse_tx(); cmp("rd_third", tx_byte, 8'hCC);
        pulse_tx(); cmp("rd_fourth", tx_byte, 8'h49);
        cs_high();
        cmp("rd_hold", tx_byte, 8'h49);

        // Wrap
        cs_low(); send_byte(8'h02); send_byte(8'hFF); send_byte(8'h11); send_byte(8'h22); cs_high();
        cs_low(); send_byte(8'h03); send_byte(8'hFF);
        cmp("wrap_ff", tx_byte, 8'h11);
        pulse_tx(); cmp("wrap_00", tx_byte, 8'h22);
        cs_high();

        // Illegal command
        cs_low();
        rx_valid = 1'b1; rx_byte = 8'h9F; tick();
        cmp("ill_pulse", {7'b0, illegal_cmd}, 8'h01);
        cmp("ill_op", {5'b0, spi_opcode}, 8'h00);
        rx_valid = 1'b0; tick();
        cmp("ill_clear", {7'b0, illegal_cmd}, 8'h00);
        send_byte(8'h02); send_byte(8'h30); send_byte(8'hEE);
        cs_high();
        cs_low(); send_byte(8'h03); send_byte(8'h30);
        cmp("ill_mem", tx_byte, 8'h6A);
        cs_high();

        // cs_n high wins over a coincident data byte
        cs_low(); send_byte(8'h02); send_byte(8'h40); send_byte(8'h01);
        cs_n = 1'b1; rx_valid = 1'b1; rx_byte = 8'h77; tick();
        rx_valid = 1'b0;
        cmp("abort_busy", {7'b0, busy}, 8'h00);
        tick();
        cs_low(); send_byte(8'h03); send_byte(8'h40);
        cmp("abort_40", tx_byte, 8'h01);
        pulse_tx(); cmp("abort_41", tx_byte, 8'h1B);
        cs_high();

        // Reset mid-frame
        cs_low(); send_byte(8'h02); send_byte(8'h20);
        rst_n = 1'b0; rx_valid = 1'b1; rx_byte = 8'h55; tick();
        rx_valid = 1'b0; tick();
        cmp("mrst_busy", {7'b0, busy}, 8'h00);
        cs_n = 1'b1; rst_n = 1'b1; tick();
        cs_low(); send_byte(8'h03); send_byte(8'h20);
        cmp("mrst_mem", tx_byte, 8'h7A);
        cs_high();
        cs_low(); send_byte(8'h02); send_byte(8'h21); send_byte(8'h99); cs_high();
        cs_low(); send_byte(8'h03); send_byte(8'h21);
        cmp("mrst_new", tx_byte, 8'h99);
        cs_high();

        // Randomized frames
        for (int f = 0; f < 80; f++) begin
            cs_n = 1'b0; tick();
            idx = 0;
            len = $urandom_range(2, 25);
            for (int c = 0; c < len; c++) begin
                rx_valid = ($urandom % 2) == 0;
                if (rx_valid) begin
                    if (idx == 0) begin
                        case ($urandom % 8)
                            0, 1, 2: rb = 8'h02;
                            3, 4, 5: rb = 8'h03;
                            default: rb = 8'($urandom);
                        endcase
                    end else begin
                        rb = 8'($urandom);
                    end
                    rx_byte = rb;
                    idx++;
                end
                tx_req = ($urandom % 3) == 0;
                rst_n  = ($urandom % 60) != 0;
                tick();
            end
            cs_n = 1'b1; rx_valid = ($urandom % 2) == 0; tx_req = ($urandom % 2) == 0; rst_n = 1'b1;
            tick();
            rx_valid = 1'b0; tx_req = 1'b0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_cmd_ctrl.md
Name: sram_cmd_ctrl

Overview:
- System-clock command/memory stage directly downstream of the SPI shift stage.
- Consumes the byte stream assembled from MOSI and decodes a 23LC-style command frame: command byte, address byte(s), data bytes.
- Owns the byte-wide SRAM array: writes received data, and supplies read data and the shift-stage opcode back upstream.
- cs_n, rx_valid and tx_req arrive already synchronized to clk.

Parameters:
- ADDR_W, 8: address width in bits, legal 1..16; DEPTH = 2**ADDR_W bytes.
- ADDR_BYTES, derived = (ADDR_W+7)/8: number of address bytes per frame.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- cs_n  input  1  chip select from master (synchronized), active-low; high ends the frame
- rx_valid  input  1  one-cycle pulse: rx_byte holds a complete received byte
- rx_byte  input  8  received byte, MSB-first as shifted in
- tx_req  input  1  one-cycle pulse: shift stage has consumed tx_byte and wants the next byte
- tx_byte  output  8  byte presented to the shift stage for MISO
- spi_opcode  output  3  shift-stage mode: 3'b000 idle, 3'b010 receive, 3'b011 transmit
- busy  output  1  high while a frame is open (state != IDLE)
- illegal_cmd  output  1  one-cycle pulse on an unrecognised command byte

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, addr=0, addr-byte counter=0, tx_byte=8'h00, spi_opcode=3'b000, busy=0, illegal_cmd=0. Array contents are not reset.
- Reset mid-frame aborts the frame. An in-flight write byte not yet committed is lost.

States:
- IDLE: spi_opcode=000. When cs_n is low, go to CMD with spi_opcode=010.
- CMD: on rx_valid, rx_byte selects the next state.
  - 8'h02 -> ADDR with mode=WRITE.
  - 8'h03 -> ADDR with mode=READ.
  - Any other value -> IGNORE; pulse illegal_cmd for one cycle.
- ADDR: each rx_valid shifts rx_byte into addr, big-endian. Bits above ADDR_W are discarded.
  - After ADDR_BYTES bytes with mode=WRITE -> WDATA.
  - After ADDR_BYTES bytes with mode=READ -> RDATA.
- WDATA: on rx_valid, mem[addr] <= rx_byte, then addr <= addr+1.
- RDATA: spi_opcode=011.
  - The cycle after entry, tx_byte <= mem[addr] and addr <= addr+1 (one-cycle registered read latency).
  - On each tx_req, tx_byte <= mem[addr] and addr <= addr+1.
  - rx_valid is ignored in this state.
- IGNORE: spi_opcode=000. All input pulses are ignored until cs_n goes high.

Frame termination and conflicts:
- cs_n high in any state -> IDLE next cycle, spi_opcode=000. cs_n high takes priority over a simultaneous rx_valid or tx_req; that byte is discarded.
- tx_req outside RDATA is ignored.
- tx_req in the same cycle as the RDATA entry fetch: only one fetch occurs, and addr increments once.

Address and output rules:
- addr wraps from DEPTH-1 to 0 in both WDATA and RDATA.
- tx_byte holds its last value outside RDATA.
- busy = (state != IDLE).

Test Plan:
- Reset: assert rst_n=0 for 2 clk, release -> tx_byte=00, spi_opcode=000, busy=0, illegal_cmd=0.
- Write burst: cs_n=0, bytes 02,10,AA,BB,CC, cs_n=1 -> mem[10]=AA, mem[11]=BB, mem[12]=CC; spi_opcode=010 during frame, then 000.
- Read burst: cs_n=0, bytes 03,10; then 3 tx_req pulses -> tx_byte sequence AA (1 clk after address byte), BB, CC, then mem[13]; spi_opcode=011 throughout.
- Wrap: write 02,FF,11,22 -> mem[FF]=11, mem[00]=22; read 03,FF plus one tx_req -> tx_byte 11 then 22.
- Illegal/abort: byte 9F -> illegal_cmd one-cycle pulse, later bytes ignored, memory unchanged. cs_n=1 on the same clk as an rx_valid of write data -> byte discarded, state IDLE.
- Reset mid-frame: 02,20,55 then rst_n=0 before the 55 rx_valid -> mem[20] unchanged, state IDLE. A new frame after release works normally.
